// File: rtl/fdma_rd_engine.sv
// Read-side FDMA engine: turns FDMA read requests into AXI4 INCR read bursts limited by
// the maximum burst length and 4 KB pages, and streams the returned beats to the consumer.
module fdma_rd_engine #(
  parameter int         AXI_DATA_WIDTH    = 128,
  parameter int         AXI_ADDR_WIDTH    = 32,
  parameter int         AXI_MAX_BURST_LEN = 64,
  parameter logic [3:0] AXI_ID            = 4'd0
) (
  input  logic                      I_ui_clk,
  input  logic                      I_ui_rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] I_fdma_raddr,
  input  logic                      I_fdma_rareq,
  input  logic [15:0]               I_fdma_rsize,
  output logic                      O_fdma_rbusy,
  output logic [AXI_DATA_WIDTH-1:0] O_fdma_rdata,
  output logic                      O_fdma_rvalid,
  input  logic                      I_fdma_rready,
  output logic                      O_fdma_rerr,
  output logic [3:0]                O_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] O_axi_araddr,
  output logic [7:0]                O_axi_arlen,
  output logic [2:0]                O_axi_arsize,
  output logic [1:0]                O_axi_arburst,
  output logic                      O_axi_arvalid,
  input  logic                      I_axi_arready,
  input  logic [3:0]                I_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] I_axi_rdata,
  input  logic [1:0]                I_axi_rresp,
  input  logic                      I_axi_rlast,
  input  logic                      I_axi_rvalid,
  output logic                      O_axi_rready
);
  localparam int                        BPB        = AXI_DATA_WIDTH / 8;
  localparam int                        LG_BPB     = $clog2(BPB);
  localparam logic [15:0]               MAX_LEN    = 16'(AXI_MAX_BURST_LEN);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~(AXI_ADDR_WIDTH'(BPB - 1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [15:0]               remain_q, remain_d;
  logic [8:0]                beat_cnt_q, beat_cnt_d;
  logic [8:0]                len_q, len_d;
  logic                      rerr_q, rerr_d;

  logic [12:0] page_beats;
  logic [15:0] len_w;
  logic [8:0]  burst_len;
  logic        ar_hs, r_hs, last_beat, beat_err;

  // Burst length: smallest of remaining beats, max burst and beats left in the 4 KB page.
  always_comb begin
    page_beats = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> LG_BPB;
    len_w      = remain_q;
    if (MAX_LEN < len_w) len_w = MAX_LEN;
    if ({3'd0, page_beats} < len_w) len_w = {3'd0, page_beats};
  end
  assign burst_len = 9'(len_w);

  assign O_fdma_rbusy  = (state_q != S_IDLE);
  assign O_axi_arvalid = (state_q == S_AR);
  assign O_axi_araddr  = O_axi_arvalid ? cur_addr_q : '0;
  assign O_axi_arlen   = O_axi_arvalid ? 8'(burst_len - 9'd1) : 8'd0;
  assign O_axi_arid    = AXI_ID;
  assign O_axi_arsize  = 3'(LG_BPB);
  assign O_axi_arburst = 2'b01;
  assign O_axi_rready  = (state_q == S_R) & I_fdma_rready;
  assign O_fdma_rvalid = (state_q == S_R) & I_axi_rvalid & I_fdma_rready;
  assign O_fdma_rdata  = I_axi_rdata;
  assign O_fdma_rerr   = rerr_q;

  assign ar_hs     = O_axi_arvalid & I_axi_arready;
  assign r_hs      = O_axi_rready & I_axi_rvalid;
  assign last_beat = (beat_cnt_q == 9'd1);
  // rlast is judged against our own beat count, not trusted for sequencing.
  assign beat_err  = (I_axi_rresp == 2'b10) | (I_axi_rresp == 2'b11) |
                     (I_axi_rlast != last_beat) | (I_axi_rid != AXI_ID);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    rerr_d     = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (I_fdma_rareq && (I_fdma_rsize != 16'd0)) begin
          cur_addr_d = I_fdma_raddr & ALIGN_MASK;
          remain_d   = I_fdma_rsize;
          rerr_d     = 1'b0;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (ar_hs) begin
          beat_cnt_d = burst_len;
          len_d      = burst_len;
          state_d    = S_R;
        end
      end
      S_R: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          remain_d   = remain_q - 16'd1;
          if (beat_err) rerr_d = 1'b1;
          if (last_beat) begin
            cur_addr_d = cur_addr_q + (AXI_ADDR_WIDTH'(len_q) << LG_BPB);
            state_d    = (remain_q != 16'd1) ? S_AR : S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_ui_clk or negedge I_ui_rstn) begin
    if (!I_ui_rstn) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      rerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      rerr_q     <= rerr_d;
    end
  end
endmodule

// File: tb/tb_fdma_rd_engine.sv
// Bench for fdma_rd_engine: AXI read slave with an address-pattern memory, scoreboard of
// expected bursts and beats, table of request vectors plus zero-length/busy and reset sequences.
module tb_fdma_rd_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]  raddr;
  logic         rareq;
  logic [15:0]  rsize;
  logic         rbusy;
  logic [127:0] fdma_rdata;
  logic         fdma_rvalid;
  logic         fdma_rready;
  logic         rerr;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   axi_rid;
  logic [127:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast;
  logic         axi_rvalid;
  logic         axi_rready;

  fdma_rd_engine #(
    .AXI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32), .AXI_MAX_BURST_LEN(64), .AXI_ID(4'd0)
  ) dut (
    .I_ui_clk(clk), .I_ui_rstn(rst_n),
    .I_fdma_raddr(raddr), .I_fdma_rareq(rareq), .I_fdma_rsize(rsize),
    .O_fdma_rbusy(rbusy), .O_fdma_rdata(fdma_rdata), .O_fdma_rvalid(fdma_rvalid),
    .I_fdma_rready(fdma_rready), .O_fdma_rerr(rerr),
    .O_axi_arid(arid), .O_axi_araddr(araddr), .O_axi_arlen(arlen), .O_axi_arsize(arsize),
    .O_axi_arburst(arburst), .O_axi_arvalid(arvalid), .I_axi_arready(arready),
    .I_axi_rid(axi_rid), .I_axi_rdata(axi_rdata), .I_axi_rresp(axi_rresp),
    .I_axi_rlast(axi_rlast), .I_axi_rvalid(axi_rvalid), .O_axi_rready(axi_rready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] size;
    bit          stall;
    int          slverr_beat;
    int          early_rlast_beat;
    bit          drop_rlast;
    int          badrid_beat;
    int          exp_nar;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    bit          exp_rerr;
  } vec_t;

  ar_t          exp_ar[$];
  ar_t          slv_q[$];
  logic [127:0] exp_data[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, idle_cyc = 0, last_beat_cyc = 0, ar_total = 0;
  int req_nar = 0, req_beats = 0, req_slv_beats = 0;
  logic [7:0] req_first = 8'd0, req_last = 8'd0;
  bit stall_en = 1'b0, inj_droplast = 1'b0;
  int inj_slverr = -1, inj_early = -1, inj_badrid = -1;

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_A5A5, ~a, a + 32'h1234_5678};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference split: min(remaining, 64, beats left in the 4 KB page), 16 bytes per beat.
  task automatic push_model(input logic [31:0] addr, input int size);
    logic [31:0] a;
    int rem, page, len;
    ar_t t;
    a   = addr & ~32'hF;
    rem = size;
    while (rem > 0) begin
      page = (4096 - int'(a[11:0])) / 16;
      len  = rem;
      if (len > 64) len = 64;
      if (len > page) len = page;
      t.addr = a;
      t.len  = 8'(len - 1);
      exp_ar.push_back(t);
      for (int i = 0; i < len; i++) exp_data.push_back(mem_word(a + 32'(16 * i)));
      a   = a + 32'(16 * len);
      rem = rem - len;
    end
  endtask

  // AXI slave, consumer and scoreboard: drive just after negedge, sample 1 ns later.
  initial begin : bfm
    logic        prev_vld;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    logic        ar_hs, r_hs;
    int          sidx;
    ar_t         t, e;
    prev_vld = 1'b0; prev_addr = '0; prev_len = '0; sidx = 0;
    arready = 1'b0; fdma_rready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    axi_rresp = 2'b00; axi_rid = 4'h0; axi_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        slv_q.delete();
        sidx = 0; prev_vld = 1'b0;
        arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
      end else begin
        arready     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        fdma_rready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (slv_q.size() > 0) begin
          t          = slv_q[0];
          axi_rvalid = 1'b1;
          axi_rdata  = mem_word(t.addr + 32'(16 * sidx));
          axi_rlast  = (sidx == int'(t.len));
          if (req_slv_beats == inj_early) axi_rlast = 1'b1;
          if (inj_droplast && (sidx == int'(t.len))) axi_rlast = 1'b0;
          axi_rresp  = (req_slv_beats == inj_slverr) ? 2'b10 : 2'b00;
          axi_rid    = (req_slv_beats == inj_badrid) ? 4'h3 : 4'h0;
        end else begin
          axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00; axi_rid = 4'h0; axi_rdata = '0;
        end
        #1;
        ar_hs = arvalid & arready;
        r_hs  = axi_rvalid & axi_rready;
        if (prev_vld) begin
          check("ar_hold_valid", 128'(arvalid), 128'(1));
          check("ar_hold_addr", 128'(araddr), 128'(prev_addr));
          check("ar_hold_len", 128'(arlen), 128'(prev_len));
        end
        prev_vld = arvalid & ~arready; prev_addr = araddr; prev_len = arlen;
        if (ar_hs) begin
          check("ar_one_outstanding", 128'(slv_q.size()), 128'(0));
          if (exp_ar.size() == 0) check("ar_unexpected_queue", 128'(exp_ar.size()), 128'(1));
          else begin
            e = exp_ar.pop_front();
            check("ar_addr", 128'(araddr), 128'(e.addr));
            check("ar_len", 128'(arlen), 128'(e.len));
          end
          t.addr = araddr; t.len = arlen;
          slv_q.push_back(t);
          if (req_nar == 0) req_first = arlen;
          req_last = arlen;
          req_nar++; ar_total++;
        end
        if (fdma_rvalid || r_hs) check("beat_handshake", 128'(fdma_rvalid), 128'(r_hs));
        if (fdma_rvalid) begin
          if (exp_data.size() == 0) check("beat_unexpected_queue", 128'(exp_data.size()), 128'(1));
          else check("fdma_rdata", fdma_rdata, exp_data.pop_front());
          req_beats++;
          last_beat_cyc = cyc;
        end
        if (r_hs) begin
          req_slv_beats++;
          if (sidx == int'(slv_q[0].len)) begin
            void'(slv_q.pop_front());
            sidx = 0;
          end else sidx++;
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [15:0] s, input bit accept);
    @(negedge clk); #2;
    raddr = a; rsize = s; rareq = 1'b1;
    if (accept) begin
      push_model(a, int'(s));
      req_nar = 0; req_beats = 0; req_slv_beats = 0; req_first = '0; req_last = '0;
    end
    @(negedge clk); #2;
    rareq = 1'b0;
    if (accept) begin
      check("req_rbusy", 128'(rbusy), 128'(1));
      check("req_arvalid", 128'(arvalid), 128'(1));
      check("req_rerr_cleared", 128'(rerr), 128'(0));
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #2;
      if (!rbusy) begin done = 1'b1; idle_cyc = cyc; end
    end
    check("idle_within_budget", 128'(done), 128'(1));
  endtask

  task automatic run_vec(input vec_t v);
    stall_en = v.stall; inj_slverr = v.slverr_beat; inj_early = v.early_rlast_beat;
    inj_droplast = v.drop_rlast; inj_badrid = v.badrid_beat;
    do_req(v.addr, v.size, 1'b1);
    wait_idle(3000);
    check("done_latency", 128'(idle_cyc - last_beat_cyc), 128'(2));
    check("scoreboard_drained", 128'(exp_ar.size() + exp_data.size()), 128'(0));
    check("beats_delivered", 128'(req_beats), 128'(v.size));
    check("n_bursts", 128'(req_nar), 128'(v.exp_nar));
    check("first_arlen", 128'(req_first), 128'(v.exp_first));
    check("last_arlen", 128'(req_last), 128'(v.exp_last));
    check("rerr_at_done", 128'(rerr), 128'(v.exp_rerr));
    stall_en = 1'b0; inj_slverr = -1; inj_early = -1; inj_droplast = 1'b0; inj_badrid = -1;
    repeat (3) @(negedge clk);
    #2;
    check("rerr_held", 128'(rerr), 128'(v.exp_rerr));
  endtask

  initial begin : main
    vec_t vecs[10];
    int   ar_before;
    bit   got;
    rareq = 1'b0; raddr = '0; rsize = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_arvalid", 128'(arvalid), 128'(0));
    check("rst_rready", 128'(axi_rready), 128'(0));
    check("rst_fdma_rvalid", 128'(fdma_rvalid), 128'(0));
    check("rst_rbusy", 128'(rbusy), 128'(0));
    check("rst_rerr", 128'(rerr), 128'(0));
    check("rst_araddr", 128'(araddr), 128'(0));
    check("rst_arlen", 128'(arlen), 128'(0));
    check("const_arid", 128'(arid), 128'(0));
    check("const_arsize", 128'(arsize), 128'(4));
    check("const_arburst", 128'(arburst), 128'(1));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    vecs[0] = '{32'h0000_0000, 16'd240, 1'b0, -1, -1, 1'b0, -1, 4, 8'd63, 8'd47, 1'b0};
    vecs[1] = '{32'h0000_0F80, 16'd16,  1'b0, -1, -1, 1'b0, -1, 2, 8'd7,  8'd7,  1'b0};
    vecs[2] = '{32'h0001_0FF0, 16'd1,   1'b0, -1, -1, 1'b0, -1, 1, 8'd0,  8'd0,  1'b0};
    vecs[3] = '{32'h0001_2340, 16'd100, 1'b1, -1, -1, 1'b0, -1, 2, 8'd63, 8'd35, 1'b0};
    vecs[4] = '{32'h0000_3000, 16'd16,  1'b0,  5,  8, 1'b0, -1, 1, 8'd15, 8'd15, 1'b1};
    vecs[5] = '{32'h0000_4000, 16'd8,   1'b0, -1, -1, 1'b0, -1, 1, 8'd7,  8'd7,  1'b0};
    vecs[6] = '{32'h0000_5000, 16'd8,   1'b0, -1, -1, 1'b1, -1, 1, 8'd7,  8'd7,  1'b1};
    vecs[7] = '{32'h0000_6000, 16'd8,   1'b0, -1, -1, 1'b0,  2, 1, 8'd7,  8'd7,  1'b1};
    vecs[8] = '{32'h0000_7FF0, 16'd3,   1'b0, -1, -1, 1'b0, -1, 2, 8'd0,  8'd1,  1'b0};
    vecs[9] = '{32'h0000_0F84, 16'd16,  1'b1, -1, -1, 1'b0, -1, 2, 8'd7,  8'd7,  1'b0};
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Zero-length request, then a request while busy.
    ar_before = ar_total;
    do_req(32'h0000_9000, 16'd0, 1'b0);
    check("zero_len_rbusy", 128'(rbusy), 128'(0));
    repeat (3) @(negedge clk);
    #2;
    check("zero_len_no_ar", 128'(ar_total - ar_before), 128'(0));
    do_req(32'h0000_9000, 16'd32, 1'b1);
    repeat (2) @(negedge clk);
    do_req(32'h0000_A000, 16'd8, 1'b0);
    check("second_req_while_busy", 128'(rbusy), 128'(1));
    wait_idle(500);
    check("busy_req_drained", 128'(exp_ar.size() + exp_data.size()), 128'(0));
    check("busy_req_ar_count", 128'(ar_total - ar_before), 128'(1));
    repeat (3) @(negedge clk);
    #2;
    check("ignored_req_no_ar", 128'(ar_total - ar_before), 128'(1));

    // Reset in the middle of the R phase.
    inj_slverr = 2;
    do_req(32'h0000_B000, 16'd64, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk); #2;
      if (req_beats >= 10) got = 1'b1;
    end
    check("midr_beats_flowing", 128'(got), 128'(1));
    check("midr_rerr_before_reset", 128'(rerr), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midr_arvalid", 128'(arvalid), 128'(0));
    check("midr_rready", 128'(axi_rready), 128'(0));
    check("midr_fdma_rvalid", 128'(fdma_rvalid), 128'(0));
    check("midr_rbusy", 128'(rbusy), 128'(0));
    check("midr_rerr", 128'(rerr), 128'(0));
    check("midr_araddr", 128'(araddr), 128'(0));
    check("midr_arlen", 128'(arlen), 128'(0));
    exp_ar.delete();
    exp_data.delete();
    inj_slverr = -1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    do_req(32'h0000_2000, 16'd20, 1'b1);
    wait_idle(500);
    check("post_reset_drained", 128'(exp_ar.size() + exp_data.size()), 128'(0));
    check("post_reset_beats", 128'(req_beats), 128'(20));
    check("post_reset_n_bursts", 128'(req_nar), 128'(1));
    check("post_reset_arlen", 128'(req_first), 128'(19));
    check("post_reset_rerr", 128'(rerr), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
